muxn_stream: RTL and testbench

- Parametrised, registered N-input, W-bit stream multiplexer.
- Successor to the plain 4:1 bit mux: generalised width and channel count, valid/ready flow control on every port, and packet-aware selection.
- Two selection modes: external select (MODE=0) or round-robin arbitration (MODE=1).
- Channel grant locks for the whole packet, up to and including the beat with last=1.
- Used wherever several producers share one downstream consumer.

---
 rtl/muxn_stream_if.sv | 27 ++
 rtl/muxn_stream.sv | 114 +++++++++++
 tb/tb_muxn_stream.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muxn_stream_if.sv
// Stream bundle between N producers, the mux and its consumer.
// The mux takes the slave view; producers/consumer drive the master view.
interface muxn_stream_if #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic [N*W-1:0] s_data;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_last;
    logic [N-1:0]   s_ready;
    logic [W-1:0]   m_data;
    logic           m_valid;
    logic           m_last;
    logic [SW-1:0]  m_chan;
    logic           m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, m_chan
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_chan
    );
endinterface

// File: rtl/muxn_stream.sv
// Registered N:1 stream mux with packet-locked grant.
// Grant comes from sel (MODE=0) or round-robin (MODE=1).
module muxn_stream #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int MODE = 0,
    parameter int SW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] sel,
    muxn_stream_if.slave  bus
);
    typedef enum logic {OPEN, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] lock_q, lock_d;
    logic [SW-1:0] rr_q, rr_d;
    logic [SW-1:0] g;
    logic [SW:0]   idx;
    logic          gv;
    logic          load_en;
    logic          acc;
    logic          last_in;
    logic [W-1:0]  data_in;
    logic [N-1:0]  ready;
    logic          mvalid_q;
    logic          mlast_q;
    logic [W-1:0]  mdata_q;
    logic [SW-1:0] mchan_q;

    assign load_en = ~mvalid_q | bus.m_ready;

    always_comb begin
        g   = '0;
        gv  = 1'b0;
        idx = '0;
        if (state_q == LOCKED) begin
            g  = lock_q;
            gv = 1'b1;
        end else if (MODE == 0) begin
            g  = sel;
            gv = ({1'b0, sel} < (SW+1)'(N));
        end else begin
            // walk downwards so the nearest channel after rr_q wins
            for (int k = N; k >= 1; k--) begin
                idx = (SW+1)'(rr_q) + (SW+1)'(k);
                if (idx >= (SW+1)'(N))
                    idx = idx - (SW+1)'(N);
                if (bus.s_valid[idx[SW-1:0]]) begin
                    g  = idx[SW-1:0];
                    gv = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (rst_n && load_en && gv)
            ready[g] = 1'b1;
    end

    assign bus.s_ready = ready;
    assign acc         = |(bus.s_valid & ready);
    assign last_in     = bus.s_last[g];
    assign data_in     = bus.s_data[int'(g)*W +: W];

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        unique case (1'b1)
            acc & last_in: begin
                state_d = OPEN;
                rr_d    = g;
            end
            acc & ~last_in: begin
                state_d = LOCKED;
                lock_d  = g;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OPEN;
            lock_q   <= '0;
            rr_q     <= SW'(N-1);
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
            mdata_q  <= '0;
            mchan_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            if (load_en) begin
                mvalid_q <= acc;
                if (acc) begin
                    mdata_q <= data_in;
                    mlast_q <= last_in;
                    mchan_q <= g;
                end
            end
        end
    end

    assign bus.m_valid = mvalid_q;
    assign bus.m_last  = mlast_q;
    assign bus.m_data  = mdata_q;
    assign bus.m_chan  = mchan_q;
endmodule

// File: tb/tb_muxn_stream.sv
// Scoreboard bench for muxn_stream: sel mode (N=4, N=3) and round-robin (N=3).
// Expected beats are queued as stimulus is accepted and popped at the output.
module tb_muxn_stream;
    typedef struct packed {
        logic [1:0] chan;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] sel0, sel1, sel2;
    int errors = 0;
    int checks = 0;
    int cnt1 [3];
    beat_t q0[$], q1[$], q2[$];

    muxn_stream_if #(.W(8), .N(4), .SW(2)) b0 ();
    muxn_stream_if #(.W(8), .N(3), .SW(2)) b1 ();
    muxn_stream_if #(.W(8), .N(3), .SW(2)) b2 ();

    muxn_stream #(.W(8), .N(4), .MODE(0), .SW(2)) u0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .bus(b0)
    );
    muxn_stream #(.W(8), .N(3), .MODE(1), .SW(2)) u1 (
        .clk(clk), .rst_n(rst_n), .sel(sel1), .bus(b1)
    );
    muxn_stream #(.W(8), .N(3), .MODE(0), .SW(2)) u2 (
        .clk(clk), .rst_n(rst_n), .sel(sel2), .bus(b2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : mon0
        beat_t e;
        if (rst_n && b0.m_valid && b0.m_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL u0_out unexpected beat got %h", {b0.m_chan, b0.m_last, b0.m_data});
            end else begin
                e = q0.pop_front();
                if ({b0.m_chan, b0.m_last, b0.m_data} !== e) begin
                    errors++;
                    $display("FAIL u0_out got %h want %h", {b0.m_chan, b0.m_last, b0.m_data}, e);
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        beat_t e;
        if (rst_n && b1.m_valid && b1.m_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1_out unexpected beat got %h", {b1.m_chan, b1.m_last, b1.m_data});
            end else begin
                e = q1.pop_front();
                if ({b1.m_chan, b1.m_last, b1.m_data} !== e) begin
                    errors++;
                    $display("FAIL u1_out got %h want %h", {b1.m_chan, b1.m_last, b1.m_data}, e);
                end
            end
        end
    end

    always @(negedge clk) begin : mon2
        beat_t e;
        if (rst_n && b2.m_valid && b2.m_ready) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL u2_out unexpected beat got %h", {b2.m_chan, b2.m_last, b2.m_data});
            end else begin
                e = q2.pop_front();
                if ({b2.m_chan, b2.m_last, b2.m_data} !== e) begin
                    errors++;
                    $display("FAIL u2_out got %h want %h", {b2.m_chan, b2.m_last, b2.m_data}, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send0(input int ch, input logic [7:0] d, input logic l);
        bit ok = 1'b0;
        b0.s_data[ch*8 +: 8] = d;
        b0.s_last[ch] = l;
        b0.s_valid[ch] = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = b0.s_ready[ch];
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send0_timeout ch=%0d data=%h got no ready want ready", ch, d);
        end else begin
            q0.push_back({2'(ch), l, d});
        end
        @(posedge clk);
        #1;
        b0.s_valid[ch] = 1'b0;
        if (ok) begin
            checks++;
            if ({b0.m_valid, b0.m_chan, b0.m_last, b0.m_data} !== {1'b1, 2'(ch), l, d}) begin
                errors++;
                $display("FAIL send0_latency got %h want %h",
                         {b0.m_valid, b0.m_chan, b0.m_last, b0.m_data}, {1'b1, 2'(ch), l, d});
            end
        end
    endtask

    task automatic run1(input int nb, input bit two);
        int got = 0;
        bit acc [3];
        b1.s_valid = 3'b111;
        for (int cyc = 0; cyc < 4*nb && got < nb; cyc++) begin
            for (int c = 0; c < 3; c++) begin
                b1.s_data[c*8 +: 8] = 8'(c*16 + cnt1[c]);
                b1.s_last[c] = (two && c == 0) ? cnt1[0][0] : 1'b1;
            end
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                acc[c] = b1.s_valid[c] & b1.s_ready[c];
                if (acc[c]) begin
                    got++;
                    cnt1[c]++;
                end
            end
            @(posedge clk);
            #1;
        end
        b1.s_valid = '0;
        checks++;
        if (got != nb) begin
            errors++;
            $display("FAIL rr_beats got %0d want %0d", got, nb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b0.s_valid = 4'($urandom);
            b0.s_last = 4'($urandom);
            b0.s_data = $urandom;
            b0.m_ready = 1'($urandom);
            b1.s_valid = 3'($urandom);
            b1.s_last = 3'($urandom);
            b1.s_data = 24'($urandom);
            b1.m_ready = 1'($urandom);
            b2.s_valid = 3'($urandom);
            b2.s_last = 3'($urandom);
            b2.s_data = 24'($urandom);
            b2.m_ready = 1'($urandom);
            sel0 = 2'($urandom);
            sel1 = 2'($urandom);
            sel2 = 2'($urandom);
            @(negedge clk);
            checks++;
            if ({b0.m_valid, b0.m_data, b0.m_chan, b0.s_ready} !== '0) begin
                errors++;
                $display("FAIL reset_u0 got %h want 0",
                         {b0.m_valid, b0.m_data, b0.m_chan, b0.s_ready});
            end
            checks++;
            if ({b1.m_valid, b1.m_data, b1.m_chan, b1.s_ready,
                 b2.m_valid, b2.m_data, b2.m_chan, b2.s_ready} !== '0) begin
                errors++;
                $display("FAIL reset_u1u2 got %h %h want 0",
                         {b1.m_valid, b1.m_data, b1.m_chan, b1.s_ready},
                         {b2.m_valid, b2.m_data, b2.m_chan, b2.s_ready});
            end
        end
        b0.s_valid = '0;
        b1.s_valid = '0;
        b2.s_valid = '0;
        b0.s_last = '0;
        b1.s_last = '0;
        b2.s_last = '0;
        b0.m_ready = 1'b1;
        b1.m_ready = 1'b1;
        b2.m_ready = 1'b1;
        sel1 = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({b0.m_valid, b1.m_valid, b2.m_valid} !== 3'b000) begin
                errors++;
                $display("FAIL idle_valid got %b want 000", {b0.m_valid, b1.m_valid, b2.m_valid});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        sel0 = 2'd2;
        send0(2, 8'h11, 1'b0);
        send0(2, 8'h22, 1'b0);
        send0(2, 8'h33, 1'b1);
    endtask

    task automatic test_lock();
        sel0 = 2'd1;
        send0(1, 8'hA0, 1'b0);
        sel0 = 2'd3;
        b0.s_data[24 +: 8] = 8'hD3;
        b0.s_last[3] = 1'b1;
        b0.s_valid[3] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (b0.s_ready !== 4'b0010) begin
                errors++;
                $display("FAIL lock_ready got %b want 0010", b0.s_ready);
            end
        end
        @(posedge clk);
        #1;
        send0(1, 8'hA1, 1'b1);
        send0(3, 8'hD3, 1'b1);
    endtask

    task automatic test_backpressure();
        sel0 = 2'd0;
        send0(0, 8'h5C, 1'b1);
        b0.m_ready = 1'b0;
        b0.s_data[0 +: 8] = 8'h5D;
        b0.s_last[0] = 1'b1;
        b0.s_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({b0.m_valid, b0.m_data, b0.s_ready} !== {1'b1, 8'h5C, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold got %h want %h",
                         {b0.m_valid, b0.m_data, b0.s_ready}, {1'b1, 8'h5C, 4'b0000});
            end
        end
        @(posedge clk);
        #1;
        b0.m_ready = 1'b1;
        q0.push_back({2'd0, 1'b1, 8'h5D});
        @(posedge clk);
        #1;
        b0.s_valid[0] = 1'b0;
        checks++;
        if ({b0.m_valid, b0.m_data} !== {1'b1, 8'h5D}) begin
            errors++;
            $display("FAIL bp_resume got %h want %h", {b0.m_valid, b0.m_data}, {1'b1, 8'h5D});
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_rr_fairness();
        for (int c = 0; c < 3; c++)
            cnt1[c] = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                q1.push_back({2'(c), 1'b1, 8'(c*16 + r)});
        run1(6, 1'b0);
        q1.push_back({2'd0, 1'b0, 8'h02});
        q1.push_back({2'd0, 1'b1, 8'h03});
        q1.push_back({2'd1, 1'b1, 8'h12});
        q1.push_back({2'd2, 1'b1, 8'h22});
        q1.push_back({2'd0, 1'b0, 8'h04});
        q1.push_back({2'd0, 1'b1, 8'h05});
        q1.push_back({2'd1, 1'b1, 8'h13});
        q1.push_back({2'd2, 1'b1, 8'h23});
        run1(8, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_invalid_sel_reset();
        b1.s_last = 3'b111;
        b1.s_data[0 +: 8] = 8'h0F;
        b1.s_valid = 3'b001;
        @(negedge clk);
        checks++;
        if (b1.s_ready !== 3'b001) begin
            errors++;
            $display("FAIL rr_single_ready got %b want 001", b1.s_ready);
        end
        q1.push_back({2'd0, 1'b1, 8'h0F});
        @(posedge clk);
        #1;
        b1.s_valid = '0;
        sel2 = 2'd3;
        b2.s_last = 3'b000;
        b2.s_valid = 3'b111;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({b2.s_ready, b2.m_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL bad_sel got %b want 0000", {b2.s_ready, b2.m_valid});
            end
        end
        @(posedge clk);
        #1;
        sel2 = 2'd1;
        b2.s_data[8 +: 8] = 8'h71;
        b2.s_valid = 3'b010;
        @(negedge clk);
        checks++;
        if (b2.s_ready !== 3'b010) begin
            errors++;
            $display("FAIL sel1_ready got %b want 010", b2.s_ready);
        end
        @(posedge clk);
        #1;
        b2.m_ready = 1'b0;
        b2.s_valid = '0;
        checks++;
        if ({b2.m_valid, b2.m_data} !== {1'b1, 8'h71}) begin
            errors++;
            $display("FAIL mid_packet got %h want %h", {b2.m_valid, b2.m_data}, {1'b1, 8'h71});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b2.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset m_valid got %b want 0", b2.m_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sel2 = 2'd0;
        b2.m_ready = 1'b1;
        b2.s_valid = 3'b111;
        b1.s_valid = 3'b111;
        @(negedge clk);
        checks++;
        if (b2.s_ready !== 3'b001) begin
            errors++;
            $display("FAIL post_reset_lock got %b want 001", b2.s_ready);
        end
        checks++;
        if (b1.s_ready !== 3'b001) begin
            errors++;
            $display("FAIL post_reset_rr got %b want 001", b1.s_ready);
        end
        #1;
        b2.s_valid = '0;
        b1.s_valid = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_lock();
        test_backpressure();
        test_rr_fairness();
        test_invalid_sel_reset();
        repeat (3) @(posedge clk);
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drained got %0d/%0d/%0d pending want 0",
                     q0.size(), q1.size(), q2.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
